// File: rtl/vga_timing_core_if.sv
// vga_timing_core_if: mode/enable inputs and raster outputs of the VGA timing core
interface vga_timing_core_if #(
    parameter int H_WIDTH = 11,
    parameter int V_WIDTH = 11
);
    logic               resolution_i;
    logic               we_i;
    logic               vga_hs_o;
    logic               vga_vs_o;
    logic [H_WIDTH-1:0] hcount_o;
    logic [V_WIDTH-1:0] vcount_o;
    logic               pixel_enable_o;
    logic               res_active_o;

    modport master (
        output resolution_i, we_i,
        input  vga_hs_o, vga_vs_o, hcount_o, vcount_o, pixel_enable_o, res_active_o
    );

    modport slave (
        input  resolution_i, we_i,
        output vga_hs_o, vga_vs_o, hcount_o, vcount_o, pixel_enable_o, res_active_o
    );
endinterface

// File: rtl/vga_timing_core.sv
// vga_timing_core: VGA raster generator for 800x600@60 and 1280x1024@60, mode switches only between frames
module vga_timing_core #(
    parameter int H_WIDTH = 11,
    parameter int V_WIDTH = 11
) (
    input  logic clk_i,
    input  logic arstn_i,
    vga_timing_core_if.slave bus
);
    localparam logic [0:0] RES_800_600   = 1'b0;
    localparam logic [0:0] RES_1280_1024 = 1'b1;

    logic [H_WIDTH-1:0] hcnt_q, hcnt_d;
    logic [V_WIDTH-1:0] vcnt_q, vcnt_d;
    logic [0:0]         res_q, res_d;
    logic [H_WIDTH-1:0] h_disp, h_sync_start, h_sync_end, h_last;
    logic [V_WIDTH-1:0] v_disp, v_sync_start, v_sync_end, v_last;
    logic               h_wrap, v_wrap;

    // Timing table for the mode currently being generated; unknown encodings use 800x600
    always_comb begin
        case (res_q)
            RES_1280_1024: begin
                h_disp       = H_WIDTH'(1280);
                h_sync_start = H_WIDTH'(1280 + 48);
                h_sync_end   = H_WIDTH'(1280 + 48 + 112);
                h_last       = H_WIDTH'(1688 - 1);
                v_disp       = V_WIDTH'(1024);
                v_sync_start = V_WIDTH'(1024 + 1);
                v_sync_end   = V_WIDTH'(1024 + 1 + 3);
                v_last       = V_WIDTH'(1066 - 1);
            end
            default: begin
                h_disp       = H_WIDTH'(800);
                h_sync_start = H_WIDTH'(800 + 40);
                h_sync_end   = H_WIDTH'(800 + 40 + 128);
                h_last       = H_WIDTH'(1056 - 1);
                v_disp       = V_WIDTH'(600);
                v_sync_start = V_WIDTH'(600 + 1);
                v_sync_end   = V_WIDTH'(600 + 1 + 4);
                v_last       = V_WIDTH'(628 - 1);
            end
        endcase
    end

    assign h_wrap = hcnt_q == h_last;
    assign v_wrap = vcnt_q == v_last;

    // Raster advance; the mode is sampled only on the last pixel of a frame
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        res_d  = res_q;
        if (bus.we_i) begin
            hcnt_d = h_wrap ? '0 : hcnt_q + H_WIDTH'(1);
            if (h_wrap) vcnt_d = v_wrap ? '0 : vcnt_q + V_WIDTH'(1);
            if (h_wrap && v_wrap) res_d = bus.resolution_i;
        end
    end

    // Counter and mode state, cleared to (0,0) in 800x600 by the async reset
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            res_q  <= RES_800_600;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            res_q  <= res_d;
        end
    end

    assign bus.hcount_o       = hcnt_q;
    assign bus.vcount_o       = vcnt_q;
    assign bus.res_active_o   = res_q[0];
    assign bus.vga_hs_o       = (hcnt_q >= h_sync_start) && (hcnt_q < h_sync_end);
    assign bus.vga_vs_o       = (vcnt_q >= v_sync_start) && (vcnt_q < v_sync_end);
    assign bus.pixel_enable_o = (hcnt_q < h_disp) && (vcnt_q < v_disp);
endmodule

// File: tb/tb_vga_timing_core.sv
// tb_vga_timing_core: directed checks of raster counting, sync windows, mode switching, freeze and reset
module tb_vga_timing_core;
    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic [10:0] vforce;
    int          n_vec = 0;
    int          n_err = 0;

    vga_timing_core_if #(.H_WIDTH(11), .V_WIDTH(11)) vif ();

    vga_timing_core #(.H_WIDTH(11), .V_WIDTH(11)) dut (
        .clk_i   (clk),
        .arstn_i (arstn),
        .bus     (vif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_pos(input string tag, input int h, input int v);
        chk({tag, ".h"}, int'(vif.hcount_o), h);
        chk({tag, ".v"}, int'(vif.vcount_o), v);
    endtask

    // skips whole lines by overwriting the line counter between clock edges
    task jump_v(input int v);
        vforce = 11'(v);
        force dut.vcnt_q = vforce;
        #1;
        release dut.vcnt_q;
    endtask

    initial begin
        vif.resolution_i = 1'b0;
        vif.we_i         = 1'b1;
        step(2);
        chk_pos("rst", 0, 0);
        chk("rst.hs", int'(vif.vga_hs_o), 0);
        chk("rst.vs", int'(vif.vga_vs_o), 0);
        chk("rst.pe", int'(vif.pixel_enable_o), 1);
        chk("rst.res", int'(vif.res_active_o), 0);
        arstn = 1'b1;
        step(839);  chk_pos("h839", 839, 0); chk("hs839", int'(vif.vga_hs_o), 0);
        step(1);    chk("hs840", int'(vif.vga_hs_o), 1); chk("pe840", int'(vif.pixel_enable_o), 0);
        step(127);  chk("hs967", int'(vif.vga_hs_o), 1);
        step(1);    chk("hs968", int'(vif.vga_hs_o), 0);
        step(87);   chk_pos("h1055", 1055, 0);
        step(1);    chk_pos("hwrap", 0, 1);
        jump_v(599);
        step(799);  chk_pos("p799_599", 799, 599); chk("pe799_599", int'(vif.pixel_enable_o), 1);
        step(1);    chk("pe800_599", int'(vif.pixel_enable_o), 0);
        step(256);  chk_pos("p0_600", 0, 600); chk("pe0_600", int'(vif.pixel_enable_o), 0);
        chk("vs600", int'(vif.vga_vs_o), 0);
        step(1056); chk("vs601", int'(vif.vga_vs_o), 1);
        step(3168); chk_pos("p0_604", 0, 604); chk("vs604", int'(vif.vga_vs_o), 1);
        step(1056); chk("vs605", int'(vif.vga_vs_o), 0);
        vif.resolution_i = 1'b1;
        step(1056); chk_pos("mid_sw", 0, 606); chk("mid_sw.res", int'(vif.res_active_o), 0);
        jump_v(627);
        step(1055); chk_pos("p1055_627", 1055, 627); chk("last.res", int'(vif.res_active_o), 0);
        step(1);    chk_pos("sw_wrap", 0, 0); chk("sw.res", int'(vif.res_active_o), 1);
        step(900);  chk_pos("h900_hi", 900, 0); chk("hs900_hi", int'(vif.vga_hs_o), 0);
        step(379);  chk("pe1279_0", int'(vif.pixel_enable_o), 1);
        step(1);    chk("pe1280_0", int'(vif.pixel_enable_o), 0);
        step(48);   chk("hs1328", int'(vif.vga_hs_o), 1);
        step(111);  chk("hs1439", int'(vif.vga_hs_o), 1);
        step(1);    chk("hs1440", int'(vif.vga_hs_o), 0);
        step(247);  chk_pos("h1687", 1687, 0);
        step(1);    chk_pos("hwrap_hi", 0, 1);
        step(500);  chk_pos("pre_frz", 500, 1);
        vif.we_i = 1'b0;
        step(50);   chk_pos("frz", 500, 1);
        chk("frz.hs", int'(vif.vga_hs_o), 0);
        chk("frz.pe", int'(vif.pixel_enable_o), 1);
        chk("frz.res", int'(vif.res_active_o), 1);
        vif.we_i = 1'b1;
        step(1);    chk_pos("unfrz", 501, 1);
        step(1187); chk_pos("p0_2", 0, 2);
        jump_v(1023);
        step(1279); chk("pe1279_1023", int'(vif.pixel_enable_o), 1);
        step(1);    chk("pe1280_1023", int'(vif.pixel_enable_o), 0);
        step(408);  chk_pos("p0_1024", 0, 1024); chk("vs1024", int'(vif.vga_vs_o), 0);
        step(1688); chk("vs1025", int'(vif.vga_vs_o), 1);
        jump_v(1027);
        chk("vs1027", int'(vif.vga_vs_o), 1);
        step(1688); chk_pos("p0_1028", 0, 1028); chk("vs1028", int'(vif.vga_vs_o), 0);
        jump_v(1065);
        step(1687); chk_pos("p1687_1065", 1687, 1065);
        step(1);    chk_pos("vwrap_hi", 0, 0); chk("vwrap.res", int'(vif.res_active_o), 1);
        step(900);
        jump_v(300);
        chk_pos("p900_300", 900, 300);
        arstn = 1'b0;
        #2;
        chk_pos("arst", 0, 0);
        chk("arst.res", int'(vif.res_active_o), 0);
        chk("arst.hs", int'(vif.vga_hs_o), 0);
        chk("arst.pe", int'(vif.pixel_enable_o), 1);
        vif.resolution_i = 1'b0;
        @(negedge clk);
        arstn = 1'b1;
        step(1);    chk_pos("post_rst", 1, 0);
        jump_v(627);
        step(1054); chk_pos("p1055_627b", 1055, 627); chk("lo.res", int'(vif.res_active_o), 0);
        vif.resolution_i = 1'b1;
        step(1);    chk_pos("lo_wrap", 0, 0); chk("edge.res", int'(vif.res_active_o), 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
